// File: rtl/sram_arbiter.sv
// Two-port (instruction fetch / data) arbiter onto a single external word SRAM.
// One transaction at a time; round-robin on contention; all SRAM pins and acks registered.
module sram_arbiter #(
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_ack,
    input  logic        d_req,
    input  logic [3:0]  d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic [19:0] sram_addr,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_we_n,
    output logic [3:0]  sram_be_n,
    output logic [31:0] sram_dq_o,
    output logic        sram_dq_oe,
    input  logic [31:0] sram_dq_i,
    output logic        stall_if,
    output logic        stall_mem
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } state_t;

    localparam logic [2:0] CNT_LAST = 3'(WAIT_CYCLES);

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        last_grant_q, last_grant_d;   // 0 = I port, 1 = D port
    logic        owner_q, owner_d;
    logic [3:0]  we_q, we_d;
    logic [31:0] i_rdata_q, i_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        i_ack_q, i_ack_d;
    logic        d_ack_q, d_ack_d;
    logic [19:0] sram_addr_q, sram_addr_d;
    logic        sram_ce_n_q, sram_ce_n_d;
    logic        sram_oe_n_q, sram_oe_n_d;
    logic        sram_we_n_q, sram_we_n_d;
    logic [3:0]  sram_be_n_q, sram_be_n_d;
    logic [31:0] sram_dq_o_q, sram_dq_o_d;
    logic        sram_dq_oe_q, sram_dq_oe_d;

    logic        grant_d_port;
    logic [31:0] sel_addr;
    logic [3:0]  sel_we;
    logic [31:0] sel_wdata;

    // On contention, the port that did not win last time gets the SRAM.
    assign grant_d_port = d_req & (~i_req | ~last_grant_q);
    assign sel_addr     = grant_d_port ? d_addr  : i_addr;
    assign sel_we       = grant_d_port ? d_we    : 4'b0000;
    assign sel_wdata    = grant_d_port ? d_wdata : 32'h0;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        we_d         = we_q;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;
        i_ack_d      = 1'b0;
        d_ack_d      = 1'b0;
        sram_addr_d  = sram_addr_q;
        sram_ce_n_d  = sram_ce_n_q;
        sram_oe_n_d  = sram_oe_n_q;
        sram_we_n_d  = sram_we_n_q;
        sram_be_n_d  = sram_be_n_q;
        sram_dq_o_d  = sram_dq_o_q;
        sram_dq_oe_d = sram_dq_oe_q;

        case (state_q)
            IDLE: begin
                if (i_req | d_req) begin
                    state_d     = ACCESS;
                    cnt_d       = 3'd0;
                    owner_d     = grant_d_port;
                    we_d        = sel_we;
                    sram_addr_d = sel_addr[21:2];
                    sram_ce_n_d = 1'b0;
                    if (sel_we != 4'b0000) begin
                        sram_oe_n_d  = 1'b1;
                        sram_we_n_d  = 1'b0;
                        sram_be_n_d  = ~sel_we;
                        sram_dq_oe_d = 1'b1;
                        sram_dq_o_d  = sel_wdata;
                    end else begin
                        sram_oe_n_d  = 1'b0;
                        sram_we_n_d  = 1'b1;
                        sram_be_n_d  = 4'b0000;
                        sram_dq_oe_d = 1'b0;
                        sram_dq_o_d  = 32'h0;
                    end
                end
            end
            ACCESS: begin
                if (cnt_q == CNT_LAST) begin
                    // Strobes drop and ack rises together as the FSM enters ACK.
                    state_d      = ACK;
                    last_grant_d = owner_q;
                    if (we_q == 4'b0000) begin
                        if (owner_q) d_rdata_d = sram_dq_i;
                        else         i_rdata_d = sram_dq_i;
                    end
                    i_ack_d      = ~owner_q;
                    d_ack_d      = owner_q;
                    sram_ce_n_d  = 1'b1;
                    sram_oe_n_d  = 1'b1;
                    sram_we_n_d  = 1'b1;
                    sram_be_n_d  = 4'b1111;
                    sram_dq_oe_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= 3'd0;
            last_grant_q <= 1'b0;
            owner_q      <= 1'b0;
            we_q         <= 4'b0000;
            i_rdata_q    <= 32'h0;
            d_rdata_q    <= 32'h0;
            i_ack_q      <= 1'b0;
            d_ack_q      <= 1'b0;
            sram_addr_q  <= 20'h0;
            sram_ce_n_q  <= 1'b1;
            sram_oe_n_q  <= 1'b1;
            sram_we_n_q  <= 1'b1;
            sram_be_n_q  <= 4'b1111;
            sram_dq_o_q  <= 32'h0;
            sram_dq_oe_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            we_q         <= we_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
            i_ack_q      <= i_ack_d;
            d_ack_q      <= d_ack_d;
            sram_addr_q  <= sram_addr_d;
            sram_ce_n_q  <= sram_ce_n_d;
            sram_oe_n_q  <= sram_oe_n_d;
            sram_we_n_q  <= sram_we_n_d;
            sram_be_n_q  <= sram_be_n_d;
            sram_dq_o_q  <= sram_dq_o_d;
            sram_dq_oe_q <= sram_dq_oe_d;
        end
    end

    assign i_rdata    = i_rdata_q;
    assign i_ack      = i_ack_q;
    assign d_rdata    = d_rdata_q;
    assign d_ack      = d_ack_q;
    assign sram_addr  = sram_addr_q;
    assign sram_ce_n  = sram_ce_n_q;
    assign sram_oe_n  = sram_oe_n_q;
    assign sram_we_n  = sram_we_n_q;
    assign sram_be_n  = sram_be_n_q;
    assign sram_dq_o  = sram_dq_o_q;
    assign sram_dq_oe = sram_dq_oe_q;
    assign stall_if   = i_req & ~i_ack_q;
    assign stall_mem  = d_req & ~d_ack_q;

    // Byte-offset and above-window address bits have no meaning for a word SRAM.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{i_addr[31:22], i_addr[1:0], d_addr[31:22], d_addr[1:0]};

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: one instance with WAIT_CYCLES=1, one with WAIT_CYCLES=0.
module tb_sram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, d_req;
    logic [31:0] i_addr, d_addr, d_wdata, sram_dq_i;
    logic [3:0]  d_we;
    logic [31:0] i_rdata, d_rdata, sram_dq_o;
    logic        i_ack, d_ack, sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe;
    logic [19:0] sram_addr;
    logic [3:0]  sram_be_n;
    logic        stall_if, stall_mem;

    logic        z_i_req, z_d_req;
    logic [31:0] z_i_addr, z_d_addr, z_d_wdata, z_dq_i;
    logic [3:0]  z_d_we;
    logic [31:0] z_i_rdata, z_d_rdata, z_dq_o;
    logic        z_i_ack, z_d_ack, z_ce_n, z_oe_n, z_we_n, z_dq_oe;
    logic [19:0] z_sram_addr;
    logic [3:0]  z_be_n;
    logic        z_stall_if, z_stall_mem;

    int checks = 0;
    int failures = 0;
    int n;

    always #5 clk = ~clk;

    sram_arbiter #(.WAIT_CYCLES(1)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .sram_addr(sram_addr), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
        .sram_we_n(sram_we_n), .sram_be_n(sram_be_n),
        .sram_dq_o(sram_dq_o), .sram_dq_oe(sram_dq_oe), .sram_dq_i(sram_dq_i),
        .stall_if(stall_if), .stall_mem(stall_mem)
    );

    sram_arbiter #(.WAIT_CYCLES(0)) dut_w0 (
        .clk(clk), .rst(rst),
        .i_req(z_i_req), .i_addr(z_i_addr), .i_rdata(z_i_rdata), .i_ack(z_i_ack),
        .d_req(z_d_req), .d_we(z_d_we), .d_addr(z_d_addr), .d_wdata(z_d_wdata),
        .d_rdata(z_d_rdata), .d_ack(z_d_ack),
        .sram_addr(z_sram_addr), .sram_ce_n(z_ce_n), .sram_oe_n(z_oe_n),
        .sram_we_n(z_we_n), .sram_be_n(z_be_n),
        .sram_dq_o(z_dq_o), .sram_dq_oe(z_dq_oe), .sram_dq_i(z_dq_i),
        .stall_if(z_stall_if), .stall_mem(z_stall_mem)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic ack_sel(input int sel);
        case (sel)
            0:       return i_ack;
            1:       return d_ack;
            2:       return i_ack | d_ack;
            default: return z_d_ack;
        endcase
    endfunction

    // Counts falling edges until the selected ack is seen, bounded by max.
    task automatic wait_ack(input int sel, input int max, output int cnt);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!ack_sel(sel) && cnt < max);
    endtask

    initial begin
        rst = 1'b1;
        i_req = 0; d_req = 0; i_addr = 0; d_addr = 0; d_wdata = 0; d_we = 0; sram_dq_i = 0;
        z_i_req = 0; z_d_req = 0; z_i_addr = 0; z_d_addr = 0; z_d_wdata = 0; z_d_we = 0; z_dq_i = 0;
        repeat (2) @(negedge clk);

        check("rst_ce_n", {31'h0, sram_ce_n}, 32'h1);
        check("rst_oe_n", {31'h0, sram_oe_n}, 32'h1);
        check("rst_we_n", {31'h0, sram_we_n}, 32'h1);
        check("rst_be_n", {28'h0, sram_be_n}, 32'hF);
        check("rst_dq_oe", {31'h0, sram_dq_oe}, 32'h0);
        check("rst_addr", {12'h0, sram_addr}, 32'h0);
        check("rst_acks", {30'h0, i_ack, d_ack}, 32'h0);
        check("rst_i_rdata", i_rdata, 32'h0);
        check("rst_d_rdata", d_rdata, 32'h0);
        rst = 1'b0;

        // Fetch read
        @(negedge clk);
        i_req = 1; i_addr = 32'h0000_0010; sram_dq_i = 32'h3C01_0001;
        @(negedge clk);
        check("rd_addr", {12'h0, sram_addr}, 32'h0000_0004);
        check("rd_ce_n", {31'h0, sram_ce_n}, 32'h0);
        check("rd_oe_n_c1", {31'h0, sram_oe_n}, 32'h0);
        check("rd_we_n", {31'h0, sram_we_n}, 32'h1);
        check("rd_be_n", {28'h0, sram_be_n}, 32'h0);
        check("rd_dq_oe", {31'h0, sram_dq_oe}, 32'h0);
        check("rd_stall_if", {31'h0, stall_if}, 32'h1);
        check("rd_ack_early1", {31'h0, i_ack}, 32'h0);
        @(negedge clk);
        check("rd_oe_n_c2", {31'h0, sram_oe_n}, 32'h0);
        check("rd_ack_early2", {31'h0, i_ack}, 32'h0);
        @(negedge clk);
        check("rd_i_ack", {31'h0, i_ack}, 32'h1);
        check("rd_d_ack", {31'h0, d_ack}, 32'h0);
        check("rd_i_rdata", i_rdata, 32'h3C01_0001);
        check("rd_oe_n_off", {31'h0, sram_oe_n}, 32'h1);
        check("rd_ce_n_off", {31'h0, sram_ce_n}, 32'h1);
        check("rd_stall_if_off", {31'h0, stall_if}, 32'h0);
        i_req = 0;
        @(negedge clk);
        check("rd_ack_width", {31'h0, i_ack}, 32'h0);
        check("rd_rdata_hold", i_rdata, 32'h3C01_0001);

        // Byte write
        d_req = 1; d_we = 4'b0100; d_addr = 32'h0000_0104; d_wdata = 32'h00AB_0000;
        sram_dq_i = 32'hDEAD_BEEF;
        @(negedge clk);
        check("wr_addr", {12'h0, sram_addr}, 32'h0000_0041);
        check("wr_be_n", {28'h0, sram_be_n}, 32'hB);
        check("wr_we_n_c1", {31'h0, sram_we_n}, 32'h0);
        check("wr_oe_n", {31'h0, sram_oe_n}, 32'h1);
        check("wr_dq_oe_c1", {31'h0, sram_dq_oe}, 32'h1);
        check("wr_dq_o", sram_dq_o, 32'h00AB_0000);
        check("wr_stall_mem", {31'h0, stall_mem}, 32'h1);
        @(negedge clk);
        check("wr_we_n_c2", {31'h0, sram_we_n}, 32'h0);
        check("wr_dq_oe_c2", {31'h0, sram_dq_oe}, 32'h1);
        check("wr_ack_early", {31'h0, d_ack}, 32'h0);
        @(negedge clk);
        check("wr_d_ack", {31'h0, d_ack}, 32'h1);
        check("wr_d_rdata", d_rdata, 32'h0);
        check("wr_we_n_off", {31'h0, sram_we_n}, 32'h1);
        check("wr_be_n_off", {28'h0, sram_be_n}, 32'hF);
        check("wr_dq_oe_off", {31'h0, sram_dq_oe}, 32'h0);
        d_req = 0; d_we = 0;
        @(negedge clk);
        check("wr_ack_width", {31'h0, d_ack}, 32'h0);

        // Simultaneous requests after reset: D first, then I
        rst = 1;
        @(negedge clk);
        rst = 0;
        i_req = 1; i_addr = 32'h0000_0020; d_req = 1; d_addr = 32'h0000_0200; d_we = 0;
        sram_dq_i = 32'h1111_2222;
        @(negedge clk);
        check("arb_first_addr", {12'h0, sram_addr}, 32'h0000_0080);
        check("arb_stall_if", {31'h0, stall_if}, 32'h1);
        check("arb_stall_mem", {31'h0, stall_mem}, 32'h1);
        wait_ack(1, 10, n);
        check("arb_d_lat", n, 2);
        check("arb_i_ack_low", {31'h0, i_ack}, 32'h0);
        check("arb_stall_if_held", {31'h0, stall_if}, 32'h1);
        d_req = 0; sram_dq_i = 32'h3333_4444;
        wait_ack(0, 10, n);
        check("arb_i_lat", n, 4);
        check("arb_i_rdata", i_rdata, 32'h3333_4444);
        check("arb_d_rdata", d_rdata, 32'h1111_2222);

        // Both held: alternate D, I, D, I
        d_req = 1;
        for (int k = 0; k < 4; k++) begin
            wait_ack(2, 10, n);
            check("alt_period", n, (k == 0) ? 4 : 3);
            check("alt_d_ack", {31'h0, d_ack}, (k % 2 == 0) ? 32'h1 : 32'h0);
            check("alt_i_ack", {31'h0, i_ack}, (k % 2 == 0) ? 32'h0 : 32'h1);
            @(negedge clk);
            check("alt_ack_width", {30'h0, i_ack, d_ack}, 32'h0);
        end
        i_req = 0; d_req = 0;
        @(negedge clk);

        // Reset during second ACCESS cycle of a write
        d_req = 1; d_we = 4'hF; d_addr = 32'h0000_0008; d_wdata = 32'h55AA_55AA;
        @(negedge clk);
        check("abort_we_n_c1", {31'h0, sram_we_n}, 32'h0);
        @(negedge clk);
        check("abort_we_n_c2", {31'h0, sram_we_n}, 32'h0);
        rst = 1; d_req = 0; d_we = 0;
        @(negedge clk);
        check("abort_we_n", {31'h0, sram_we_n}, 32'h1);
        check("abort_ce_n", {31'h0, sram_ce_n}, 32'h1);
        check("abort_be_n", {28'h0, sram_be_n}, 32'hF);
        check("abort_dq_oe", {31'h0, sram_dq_oe}, 32'h0);
        check("abort_d_ack", {31'h0, d_ack}, 32'h0);
        rst = 0;
        @(negedge clk);
        check("abort_d_ack2", {31'h0, d_ack}, 32'h0);
        i_req = 1; i_addr = 32'h0000_0040;
        @(negedge clk);
        check("abort_idle_grant", {31'h0, sram_ce_n}, 32'h0);
        check("abort_idle_addr", {12'h0, sram_addr}, 32'h0000_0010);
        wait_ack(0, 10, n);
        check("abort_next_lat", n, 2);
        i_req = 0;
        @(negedge clk);

        // WAIT_CYCLES=0 read at top of address window
        z_d_req = 1; z_d_addr = 32'hFFFF_FFFC; z_dq_i = 32'hCAFE_F00D;
        @(negedge clk);
        check("w0_addr", {12'h0, z_sram_addr}, 32'h000F_FFFF);
        check("w0_oe_n", {31'h0, z_oe_n}, 32'h0);
        check("w0_ack_early", {31'h0, z_d_ack}, 32'h0);
        @(negedge clk);
        check("w0_d_ack", {31'h0, z_d_ack}, 32'h1);
        check("w0_d_rdata", z_d_rdata, 32'hCAFE_F00D);
        check("w0_oe_n_off", {31'h0, z_oe_n}, 32'h1);
        z_d_req = 0;
        @(negedge clk);
        check("w0_ack_width", {31'h0, z_d_ack}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
